mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-ported unified instruction/data memory of the pipelined RV32 core. Each cycle it grants the port to either instruction fetch (IF) or the MEM-stage data access. It drives the port address-select mux and the port read/write strobes, tracks which requester owns the one-cycle-latency read response, and issues fetch stall/bubble and data stall to the pipeline. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- ADDR_W, 6, word address width of the memory port.
- DATA_W, 32, read data width.
- STARVE_LIM, 3, maximum consecutive data grants while a fetch is waiting; legal range 1..15.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch word address.
- d_rd  in  1  MEM-stage load request.
- d_wr  in  1  MEM-stage store request.
- d_addr  in  ADDR_W  data word address.
- port_rdata  in  DATA_W  memory read data, valid the cycle after port_re.
- port_sel  out  1  address mux select: 0 = if_addr, 1 = d_addr.
- port_addr  out  ADDR_W  selected address.
- port_re  out  1  memory read strobe.
- port_we  out  1  memory write strobe.
- if_gnt  out  1  fetch accepted this cycle.
- if_stall  out  1  hold PC: if_req & ~if_gnt.
- if_rvalid  out  1  port_rdata is the instruction fetched last cycle.
- if_bubble  out  1  IF/ID must load NOP this cycle.
- d_gnt  out  1  data access accepted this cycle.
- d_stall  out  1  hold MEM stage and upstream: (d_rd|d_wr) & ~d_gnt.
- d_rvalid  out  1  port_rdata is the load data requested last cycle.
- rdata  out  DATA_W  pass-through of port_rdata.
- err  out  1  sticky error flag: d_rd and d_wr were both seen high.

## Operation
Grant logic is combinational from the requests and registered state.
- d_req = d_rd | d_wr.
- Starvation check: if d_req & if_req & (run_cnt == STARVE_LIM), then if_gnt = 1 and d_gnt = 0.
- Otherwise, if d_req, then d_gnt = 1.
- Otherwise, if if_req, then if_gnt = 1.
- Otherwise, the port is idle.

Port signals:
- port_sel = d_gnt; port_addr follows port_sel.
- port_we = d_gnt & d_wr.
- port_re = if_gnt | (d_gnt & d_rd & ~d_wr).
- d_rd & d_wr together is treated as a write and sets err. err clears only on rst.

Starvation counter run_cnt, 4 bits:
- Increments when d_gnt & if_req.
- Clears to 0 when if_gnt or ~if_req.
- Never exceeds STARVE_LIM.

Response FSM resp, registered, one of three states:
- R_NONE: no response outstanding.
- R_IF: fetch response outstanding.
- R_D: load response outstanding.

Next-state rule:
- if_gnt → R_IF.
- d_gnt & port_re → R_D.
- Anything else (store or idle) → R_NONE.

Response outputs:
- if_rvalid = (resp == R_IF).
- d_rvalid = (resp == R_D).
- rdata = port_rdata unconditionally.
- if_bubble = ~if_rvalid & ifq_d, where ifq_d is if_req registered. A fetch was wanted last cycle but not served, so IF/ID takes a NOP.

## Timing
- Grant, stall and port_* outputs are combinational, with zero latency from the requests.
- Read data returns exactly 1 cycle after grant.
- Store completes at the grant-cycle edge and produces no response.
- A fetch is granted no later than STARVE_LIM+1 cycles after if_req rises, even under continuous d_req.
- Back-to-back grants are allowed every cycle; R_IF/R_D may follow each other without idle cycles.
- Reset asserted, asynchronous:
  - resp = R_NONE, run_cnt = 0, ifq_d = 0, err = 0.
  - if_rvalid = d_rvalid = if_bubble = 0.
  - A response in flight is dropped.
  - Combinational grant outputs keep following the requests during reset.
- Requests that change during a stall cycle are re-evaluated fresh each cycle; no request is latched.

## Test plan
- Fetch only: if_req = 1, if_addr = 5 for 4 cycles → if_gnt = 1, port_sel = 0, port_addr = 5 each cycle; if_rvalid = 1 from cycle 2 onward; if_bubble = 0.
- Load conflict: if_req = 1 and d_rd = 1, d_addr = 0x2A in one cycle → d_gnt = 1, port_sel = 1, if_stall = 1. Next cycle: d_rvalid = 1, if_bubble = 1, rdata = memory[0x2A].
- Starvation: if_req = 1 and d_wr = 1 held for 8 cycles, STARVE_LIM = 3 → grant pattern D,D,D,IF,D,D,D,IF; port_we low on the IF cycles; run_cnt peaks at 3.
- Store then load: d_wr to address 7 with data 0xDEADBEEF, then d_rd of address 7 → the store yields no d_rvalid; the load yields d_rvalid = 1 and rdata = 0xDEADBEEF on the following cycle.
- Reset mid-read: grant a fetch, then assert rst before the next edge → if_rvalid = 0 and if_bubble = 0 immediately. After rst release, run_cnt = 0 and the first grant follows the rules above.
- Illegal request: d_rd = d_wr = 1 → port_we = 1, port_re = 0, err = 1 and stays 1 until rst.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the unified I/D memory: data has priority,
// a starvation counter guarantees fetch progress, and a response FSM tags read data.
module mem_port_arbiter #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] port_rdata,
   output logic              port_sel,
   output logic [ADDR_W-1:0] port_addr,
   output logic              port_re,
   output logic              port_we,
   output logic              if_gnt,
   output logic              if_stall,
   output logic              if_rvalid,
   output logic              if_bubble,
   output logic              d_gnt,
   output logic              d_stall,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   typedef enum logic [1:0] {R_NONE, R_IF, R_D} resp_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   resp_t      resp, resp_nxt;
   logic [3:0] run_cnt, run_nxt;
   logic       ifq_d;
   logic       d_req;

   always_comb begin
      d_req    = d_rd | d_wr;
      if_gnt   = 1'b0;
      d_gnt    = 1'b0;
      run_nxt  = '0;
      resp_nxt = R_NONE;
      // Starved fetch wins over a pending data access exactly once per window.
      if (d_req && if_req && (run_cnt == LIM))
         if_gnt = 1'b1;
      else if (d_req)
         d_gnt = 1'b1;
      else if (if_req)
         if_gnt = 1'b1;

      port_sel  = d_gnt;
      port_addr = port_sel ? d_addr : if_addr;
      port_we   = d_gnt & d_wr;
      port_re   = if_gnt | (d_gnt & d_rd & ~d_wr);
      if_stall  = if_req & ~if_gnt;
      d_stall   = d_req & ~d_gnt;

      if (d_gnt && if_req)
         run_nxt = run_cnt + 4'd1;

      if (if_gnt)
         resp_nxt = R_IF;
      else if (d_gnt && port_re)
         resp_nxt = R_D;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp    <= R_NONE;
         run_cnt <= '0;
         ifq_d   <= 1'b0;
         err     <= 1'b0;
      end else begin
         resp    <= resp_nxt;
         run_cnt <= run_nxt;
         ifq_d   <= if_req;
         if (d_rd && d_wr)
            err <= 1'b1;
      end
   end

   assign if_rvalid = (resp == R_IF);
   assign d_rvalid  = (resp == R_D);
   assign if_bubble = ~if_rvalid & ifq_d;
   assign rdata     = port_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level
// reference model of grant priority, fetch starvation and read responses.
module tb_mem_port_arbiter;

   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
   logic [AW-1:0] if_addr = '0, d_addr = '0;
   logic [DW-1:0] port_rdata = '0, wdata = '0;
   logic          port_sel, port_re, port_we, if_gnt, if_stall, if_rvalid, if_bubble;
   logic          d_gnt, d_stall, d_rvalid, err;
   logic [AW-1:0] port_addr;
   logic [DW-1:0] rdata;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .port_rdata(port_rdata),
      .port_sel(port_sel), .port_addr(port_addr), .port_re(port_re), .port_we(port_we),
      .if_gnt(if_gnt), .if_stall(if_stall), .if_rvalid(if_rvalid), .if_bubble(if_bubble),
      .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   // Memory attached to the DUT port, driven only by the DUT's strobes.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (port_re) port_rdata <= mem[port_addr];
      if (port_we) mem[port_addr] <= wdata;
   end

   // Reference model state.
   logic [DW-1:0] smem [64];
   int            checks = 0, errors = 0;
   int            waits;          // data grants taken while fetch was waiting
   int            m_resp;         // 0 none, 1 fetch data due, 2 load data due
   logic [DW-1:0] m_rd;
   bit            m_ifq, m_err;
   string         gpat;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      waits = 0; m_resp = 0; m_ifq = 0; m_err = 0;
   endtask

   // One cycle: drive, check combinational and response outputs, advance model.
   task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] wd);
      bit dq, eif, ed, ere;
      if_req = ir; if_addr = ia; d_rd = dr; d_wr = dw; d_addr = da; wdata = wd;
      #1;
      dq  = dr | dw;
      eif = (ir && !dq) || (ir && dq && waits == LIM);
      ed  = dq && !eif;
      ere = eif || (ed && dr && !dw);
      gpat = {gpat, eif ? "I" : (ed ? "D" : "-")};
      check("if_gnt",   if_gnt,   eif);
      check("d_gnt",    d_gnt,    ed);
      check("if_stall", if_stall, ir && !eif);
      check("d_stall",  d_stall,  dq && !ed);
      check("port_sel", port_sel, ed);
      check("port_addr", port_addr, ed ? da : ia);
      check("port_we",  port_we,  ed && dw);
      check("port_re",  port_re,  ere);
      check("if_rvalid", if_rvalid, m_resp == 1);
      check("d_rvalid", d_rvalid, m_resp == 2);
      check("if_bubble", if_bubble, (m_resp != 1) && m_ifq);
      check("err",      err,      m_err);
      if (m_resp != 0) check("rdata", rdata, m_rd);
      @(posedge clk);
      if (eif) begin m_resp = 1; m_rd = smem[ia]; end
      else if (ed && dr && !dw) begin m_resp = 2; m_rd = smem[da]; end
      else m_resp = 0;
      if (ed && dw) smem[da] = wd;
      waits = (ed && ir) ? waits + 1 : 0;
      m_ifq = ir;
      if (dr && dw) m_err = 1;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]  = $urandom;
         smem[i] = mem[i];
      end
      model_reset();
      gpat = "";
      #1;
      check("rst_if_rvalid", if_rvalid, 1'b0);
      check("rst_d_rvalid",  d_rvalid,  1'b0);
      check("rst_bubble",    if_bubble, 1'b0);
      check("rst_err",       err,       1'b0);
      @(posedge clk); #1 rst = 1'b0;

      // Fetch only
      for (int i = 0; i < 4; i++) step(1, 6'd5, 0, 0, '0, '0);
      step(0, '0, 0, 0, '0, '0);
      // Load conflicting with fetch, then idle to see response and bubble
      step(1, 6'd1, 1, 0, 6'h2A, '0);
      step(0, '0, 0, 0, '0, '0);
      // Starvation: fetch and store held together
      gpat = "";
      for (int i = 0; i < 8; i++) step(1, 6'd3, 0, 1, 6'd9, $urandom);
      check("starve_pattern", (gpat == "DDDIDDDI"), 1'b1);
      step(0, '0, 0, 0, '0, '0);
      // Store then load of the same word
      step(0, '0, 0, 1, 6'd7, 32'hDEADBEEF);
      step(0, '0, 1, 0, 6'd7, '0);
      step(0, '0, 0, 0, '0, '0);
      check("store_load_data", smem[7], 32'hDEADBEEF);

      // Reset while a fetch response is in flight
      step(1, 6'd4, 0, 0, '0, '0);
      #2 rst = 1'b1;
      #1;
      check("rstmid_if_rvalid", if_rvalid, 1'b0);
      check("rstmid_bubble",    if_bubble, 1'b0);
      check("rstmid_if_gnt",    if_gnt,    1'b1);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      step(1, 6'd2, 1, 0, 6'd8, '0);

      // Randomized traffic (illegal rd+wr excluded here)
      for (int i = 0; i < 400; i++) begin
         bit r_ir, r_dr, r_dw;
         r_ir = ($urandom_range(0, 3) != 0);
         r_dr = ($urandom_range(0, 2) == 0);
         r_dw = !r_dr && ($urandom_range(0, 2) == 0);
         step(r_ir, AW'($urandom), r_dr, r_dw, AW'($urandom), $urandom);
      end

      // Illegal rd+wr: treated as a store, err sticks until reset
      step(0, '0, 1, 1, 6'd11, 32'h1234_5678);
      for (int i = 0; i < 3; i++) step(1, 6'd11, 0, 0, '0, '0);
      check("illegal_store", smem[11], 32'h1234_5678);
      rst = 1'b1; #1;
      check("err_cleared", err, 1'b0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      step(1, 6'd11, 0, 0, '0, '0);
      step(0, '0, 0, 0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
